// File: rtl/radar_sweep_capture_pkg.sv
// Shared types and widths for the radar sweep capture block.
package radar_pkg;

    localparam int VID_W = 12;
    localparam int AZ_W  = 12;
    localparam int BIN_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLANK   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    typedef struct packed {
        logic [VID_W-1:0] data;
        logic [BIN_W-1:0] bin;
        logic [AZ_W-1:0]  az;
        logic             last;
    } entry_t;

endpackage

// File: rtl/radar_sweep_capture_fifo.sv
// First-word fall-through FIFO; the head is a register that holds its value once the FIFO drains.
module sweep_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_rd_next;
    logic [AW:0]      w_remain;

    // A pop frees its slot before the push is judged, so push+pop when full is accepted.
    assign w_pop     = i_pop && (r_count != '0);
    assign w_push    = i_push && ((r_count != FULL_CNT) || w_pop);
    assign w_rd_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_remain  = r_count - {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Older stored entries take the head first; an empty FIFO takes the incoming word.
            if (w_remain != '0) begin
                r_head <= r_mem[w_rd_next];
            end else if (w_push) begin
                r_head <= i_wdata;
            end
        end
    end

    assign o_rdata = r_head;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/radar_sweep_capture.sv
// Captures one range sweep per master trigger into a FIFO, tagged with bin and azimuth.
// Optional clutter gating of low-level video is enabled by defining CLUTTER_GATE_EN.
module radar_sweep_capture
    import radar_pkg::*;
#(
    parameter int NUM_BINS   = 1024,
    parameter int BIN_W      = radar_pkg::BIN_W,
    parameter int FIFO_DEPTH = 64,
    parameter int VID_W      = radar_pkg::VID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             acp,
    input  logic             arp,
    input  logic [VID_W-1:0] video,
    input  logic             sample_en,
`ifdef CLUTTER_GATE_EN
    input  logic [VID_W-1:0] gate_thr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VID_W-1:0] out_data,
    output logic [BIN_W-1:0] out_bin,
    output logic [AZ_W-1:0]  out_az,
    output logic             out_last,
    output logic             overflow,
    output logic             trunc,
    output logic [AZ_W-1:0]  az_cnt,
    output state_e           o_state
);

    localparam int ENTRY_W = VID_W + BIN_W + AZ_W + 1;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    logic               r_trig_q;
    logic               r_acp_q;
    logic               r_arp_q;
    logic [AZ_W-1:0]    r_az_cnt;
    logic [AZ_W-1:0]    r_sweep_az;
    logic [BIN_W-1:0]   r_bin_cnt;
    state_e             r_state;
    logic               r_overflow;
    logic               r_trunc;

    logic               w_trig_rise;
    logic               w_acp_rise;
    logic               w_arp_rise;
    logic               w_push;
    logic               w_last;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [VID_W-1:0]   w_video;
    logic [ENTRY_W-1:0] w_wr_data;
    logic [ENTRY_W-1:0] w_rd_data;

    assign w_trig_rise = trig & ~r_trig_q;
    assign w_acp_rise  = acp & ~r_acp_q;
    assign w_arp_rise  = arp & ~r_arp_q;

`ifdef CLUTTER_GATE_EN
    assign w_video = (video < gate_thr) ? '0 : video;
`else
    assign w_video = video;
`endif

    assign w_push    = (r_state == CAPTURE) && sample_en;
    assign w_last    = (r_bin_cnt == LAST_BIN);
    assign w_wr_data = {w_video, r_bin_cnt, r_sweep_az, w_last};
    assign w_pop     = ~w_empty & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trig_q   <= 1'b0;
            r_acp_q    <= 1'b0;
            r_arp_q    <= 1'b0;
            r_az_cnt   <= '0;
            r_sweep_az <= '0;
            r_bin_cnt  <= '0;
            r_state    <= IDLE;
            r_overflow <= 1'b0;
            r_trunc    <= 1'b0;
        end else begin
            r_trig_q <= trig;
            r_acp_q  <= acp;
            r_arp_q  <= arp;

            if (w_arp_rise) begin
                r_az_cnt <= '0;
            end else if (w_acp_rise) begin
                r_az_cnt <= r_az_cnt + 1'b1;
            end

            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_trig_rise) begin
                        r_sweep_az <= r_az_cnt;
                        r_state    <= BLANK;
                    end
                end
                BLANK: begin
                    if (!trig) begin
                        r_bin_cnt <= '0;
                        r_state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Bin advances even on a dropped push so numbering stays tied to range.
                    if (sample_en) begin
                        r_bin_cnt <= r_bin_cnt + 1'b1;
                    end
                    if (w_trig_rise) begin
                        if (!(sample_en && w_last)) r_trunc <= 1'b1;
                        r_sweep_az <= r_az_cnt;
                        r_state    <= BLANK;
                    end else if (sample_en && w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sweep_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wr_data),
        .i_pop   (w_pop),
        .o_rdata (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_data  = w_rd_data[ENTRY_W-1 -: VID_W];
    assign out_bin   = w_rd_data[AZ_W+BIN_W -: BIN_W];
    assign out_az    = w_rd_data[AZ_W -: AZ_W];
    assign out_last  = w_rd_data[0];
    assign overflow  = r_overflow;
    assign trunc     = r_trunc;
    assign az_cnt    = r_az_cnt;
    assign o_state   = r_state;

endmodule

// File: tb/tb_radar_sweep_capture.sv
// Scoreboard bench for radar_sweep_capture (NUM_BINS=8, FIFO_DEPTH=4); also builds with CLUTTER_GATE_EN.
module tb_radar_sweep_capture;
  import radar_pkg::*;

  localparam int NB    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trig = 1'b0;
  logic        acp = 1'b0;
  logic        arp = 1'b0;
  logic [11:0] video = '0;
  logic        sample_en = 1'b0;
  logic        out_ready = 1'b0;
`ifdef CLUTTER_GATE_EN
  logic [11:0] gate_thr = 12'h080;
`endif
  logic        out_valid;
  logic [11:0] out_data;
  logic [15:0] out_bin;
  logic [11:0] out_az;
  logic        out_last;
  logic        overflow;
  logic        trunc;
  logic [11:0] az_cnt;
  state_e      o_state;

  radar_sweep_capture #(
    .NUM_BINS   (NB),
    .BIN_W      (16),
    .FIFO_DEPTH (DEPTH),
    .VID_W      (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .acp       (acp),
    .arp       (arp),
    .video     (video),
    .sample_en (sample_en),
`ifdef CLUTTER_GATE_EN
    .gate_thr  (gate_thr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bin   (out_bin),
    .out_az    (out_az),
    .out_last  (out_last),
    .overflow  (overflow),
    .trunc     (trunc),
    .az_cnt    (az_cnt),
    .o_state   (o_state)
  );

  // clock / reset
  always #10 clk = ~clk;

  // reference model state
  entry_t exp_q[$];
  entry_t last_pop = '0;
  int     n_tests = 0;
  int     n_fail = 0;
  int     m_az = 0;
  int     m_bin = 0;
  int     m_sweep_az = 0;
  bit     m_capt = 0;
  bit     m_ovf = 0;
  bit     m_trunc = 0;
  bit     rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] gated(input logic [11:0] v);
`ifdef CLUTTER_GATE_EN
    return (v < 12'h080) ? 12'h000 : v;
`else
    return v;
`endif
  endfunction

  // Expected entry for a strobe during a live sweep; dropped when the FIFO is full and not draining.
  task automatic model_push(input logic [11:0] v);
    entry_t e;
    e.data = gated(v);
    e.bin  = 16'(m_bin);
    e.az   = 12'(m_sweep_az);
    e.last = (m_bin == NB - 1);
    if (exp_q.size() >= DEPTH && !out_ready) m_ovf = 1;
    else exp_q.push_back(e);
    m_bin++;
    if (m_bin == NB) m_capt = 0;
  endtask

  // driver tasks
  task automatic cycle(input bit se, input logic [11:0] v);
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    sample_en = se;
    video = v;
    if (se && m_capt) model_push(v);
  endtask

  task automatic strobe(input logic [11:0] v);
    cycle(1'b1, v);
    cycle(1'b0, '0);
  endtask

  task automatic acp_pulse();
    cycle(1'b0, '0);
    acp = 1'b1;
    m_az = (m_az + 1) % 4096;
    cycle(1'b0, '0);
    acp = 1'b0;
  endtask

  task automatic trig_pulse(input int width, input bit blank_strobes);
    cycle(1'b0, '0);
    trig = 1'b1;
    if (m_capt) begin
      m_trunc = 1;
      m_capt  = 0;
    end
    m_sweep_az = m_az;
    for (int k = 0; k < width; k++) cycle(blank_strobes && (k % 2 == 1), 12'($urandom));
    trig = 1'b0;
    m_capt = 1;
    m_bin  = 0;
  endtask

  task automatic drain();
    rand_ready = 0;
    out_ready  = 1'b1;
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) cycle(1'b0, '0);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    cycle(1'b0, '0);
    check("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  // scoreboard monitor: an entry transfers at the coming edge when valid && ready
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_entry: got data=%h bin=%0d az=%0d last=%0b, required no entry",
                 out_data, out_bin, out_az, out_last);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        if ({out_data, out_bin, out_az, out_last} !== e) begin
          n_fail++;
          $display("FAIL entry: got data=%h bin=%0d az=%0d last=%0b, required data=%h bin=%0d az=%0d last=%0b",
                   out_data, out_bin, out_az, out_last, e.data, e.bin, e.az, e.last);
        end
        last_pop = e;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_az;
    int nstr;

    #5;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_az_cnt", 64'(az_cnt), 64'd0);
    check("rst_state", 64'(o_state), 64'(IDLE));
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_trunc", 64'(trunc), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    #40;
    rst = 1'b1;

    // basic sweep: 5 acp, 50-clk trigger, 8 samples
    out_ready = 1'b1;
    repeat (5) acp_pulse();
    cycle(1'b0, '0);
    check("az_after_5_acp", 64'(az_cnt), 64'd5);
    trig_pulse(50, 0);
    for (int i = 0; i < NB; i++) strobe(12'(12'h100 + i));
    drain();
    check("basic_overflow", 64'(overflow), 64'd0);
    check("basic_trunc", 64'(trunc), 64'd0);
    check("basic_state_idle", 64'(o_state), 64'(IDLE));

    // azimuth: reach 17, simultaneous arp/acp, then full wrap
    repeat (12) acp_pulse();
    cycle(1'b0, '0);
    check("az_17", 64'(az_cnt), 64'(m_az));
    cycle(1'b0, '0);
    acp = 1'b1;
    arp = 1'b1;
    m_az = 0;
    cycle(1'b0, '0);
    acp = 1'b0;
    arp = 1'b0;
    cycle(1'b0, '0);
    check("az_arp_acp_same", 64'(az_cnt), 64'd0);
    acp_pulse();
    cycle(1'b0, '0);
    check("az_after_arp_acp", 64'(az_cnt), 64'd1);
    start_az = m_az;
    repeat (4096) acp_pulse();
    cycle(1'b0, '0);
    check("az_wrap", 64'(az_cnt), 64'(start_az));

    // overflow: hold the consumer off for five samples
    out_ready = 1'b0;
    trig_pulse(10, 0);
    for (int i = 0; i < 5; i++) strobe(12'($urandom));
    check("ovf_set", 64'(overflow), 64'(m_ovf));
    check("ovf_held_valid", 64'(out_valid), 64'd1);
    check("ovf_held_bin0", 64'(out_bin), 64'd0);
    drain();
    check("hold_bin_after_drain", 64'(out_bin), 64'(last_pop.bin));
    check("hold_data_after_drain", 64'(out_data), 64'(last_pop.data));
    for (int i = 5; i < NB; i++) strobe(12'($urandom));
    drain();

    // truncation: new trigger after bin 3
    acp_pulse();
    trig_pulse(10, 0);
    for (int i = 0; i < 4; i++) strobe(12'($urandom));
    acp_pulse();
    acp_pulse();
    trig_pulse(10, 0);
    cycle(1'b0, '0);
    check("trunc_set", 64'(trunc), 64'(m_trunc));
    for (int i = 0; i < NB; i++) strobe(12'($urandom));
    drain();
    check("trunc_state_idle", 64'(o_state), 64'(IDLE));

    // strobes during blanking, then gate sequence
    trig_pulse(12, 1);
    cycle(1'b0, '0);
    check("blank_no_writes", 64'(out_valid), 64'd0);
    check("blank_then_capture", 64'(o_state), 64'(CAPTURE));
    strobe(12'h07F);
    strobe(12'h080);
    strobe(12'h200);
    for (int i = 3; i < NB; i++) strobe(12'($urandom));
    drain();

    // asynchronous reset mid-capture
    out_ready = 1'b0;
    trig_pulse(6, 0);
    for (int i = 0; i < 3; i++) strobe(12'($urandom));
    cycle(1'b0, '0);
    #4;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_state", 64'(o_state), 64'(IDLE));
    check("async_rst_overflow", 64'(overflow), 64'd0);
    check("async_rst_trunc", 64'(trunc), 64'd0);
    check("async_rst_az", 64'(az_cnt), 64'd0);
    exp_q.delete();
    m_az = 0;
    m_capt = 0;
    m_ovf = 0;
    m_trunc = 0;
    #3;
    rst = 1'b1;

    // randomized sweeps with a random consumer
    rand_ready = 1;
    for (int s = 0; s < 6; s++) begin
      trig_pulse($urandom_range(3, 20), 0);
      nstr = (s != 5 && $urandom_range(0, 2) == 0) ? $urandom_range(1, NB - 1) : NB;
      for (int i = 0; i < nstr; i++) begin
        cycle(1'b1, 12'($urandom));
        repeat ($urandom_range(0, 2)) cycle(1'b0, '0);
        if ($urandom_range(0, 4) == 0) acp_pulse();
      end
    end
    drain();
    check("rand_overflow", 64'(overflow), 64'(m_ovf));
    check("rand_trunc", 64'(trunc), 64'(m_trunc));
    check("rand_az", 64'(az_cnt), 64'(m_az));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/radar_sweep_capture.md
Name: radar_sweep_capture

Overview:
- Downstream consumer of the radar interface video and timing signals: trig, acp, arp, video.
- On every master-trigger pulse it captures one sweep of range samples into an internal FIFO.
- Each sample is tagged with its range bin and the azimuth count latched at trigger time.
- Samples stream out over a valid/ready interface to the downstream processing or display path.
- All inputs share the system 50 MHz clock; the 25 MHz video cadence arrives as the sample_en strobe.

Parameters:
- NUM_BINS, 1024, range bins captured per sweep; allowed range 2..65535.
- BIN_W, 16, width of the range-bin index.
- FIFO_DEPTH, 64, output FIFO entries; power of two, 4 or more.
- VID_W, 12, video sample width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-low.
- trig  in  1  master trigger, high during pulse transmission.
- acp  in  1  azimuth change pulse, level signal.
- arp  in  1  azimuth reset pulse, level signal.
- video  in  VID_W  radar video sample.
- sample_en  in  1  one-cycle strobe; video is valid on this cycle.
- out_valid  out  1  output entry available.
- out_ready  in  1  consumer accepts the entry.
- out_data  out  VID_W  captured sample.
- out_bin  out  BIN_W  range index, 0..NUM_BINS-1.
- out_az  out  12  azimuth count for the sweep.
- out_last  out  1  marks bin NUM_BINS-1.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- trunc  out  1  sticky: a sweep was aborted by a new trigger.
- az_cnt  out  12  live azimuth counter.

Behaviour:
- Reset (rst=0): all outputs 0, FIFO empty, state IDLE, azimuth counter 0, edge-detect registers 0.
- Edge detection: trig, acp and arp each pass through one register stage. A rising edge is current=1 with previous=0, so edges are seen one clk after the input changes.
- Azimuth counter:
  - acp rise: az_cnt increments, wrapping 4095 -> 0.
  - arp rise: az_cnt is set to 0.
  - arp rise and acp rise in the same cycle: the result is 0.
- State machine, three states:
  - IDLE: on trig rise, latch az_cnt into sweep_az and go to BLANK.
  - BLANK: ignore sample_en. When trig is detected low, clear bin_cnt to 0 and go to CAPTURE.
  - CAPTURE: on each sample_en, push {video, bin_cnt, sweep_az, last=(bin_cnt==NUM_BINS-1)} and increment bin_cnt. After the push with last=1, go to IDLE.
  - CAPTURE with trig rise: set trunc, latch the new az_cnt and go to BLANK. The push in that cycle, if any, still happens. No out_last is emitted for the aborted sweep.
- Triggers in BLANK are ignored. trig is continuously high there, so no rise occurs.
- Push while FIFO full: the entry is dropped and overflow is set. bin_cnt still advances, so bin numbering stays aligned to range.
- Output side:
  - out_* reflect the FIFO head.
  - A transfer happens when out_valid and out_ready are both 1.
  - A simultaneous push and pop when full is allowed: the pop frees the slot first, so no drop.
  - Empty FIFO: out_valid=0 and out_data/out_bin/out_az/out_last hold their last values.
- Latency: video arriving with sample_en appears at out_valid one clk later when the FIFO was empty (registered write, first-word fall-through).
- overflow and trunc clear only on reset.

Optional Feature:
- Macro: CLUTTER_GATE_EN.
- Defined:
  - Adds input port gate_thr (VID_W).
  - A sample with video < gate_thr is pushed as 0; bin and azimuth tags are unchanged.
  - gate_thr is sampled in the same cycle as sample_en.
- Undefined: the port is absent and video passes unmodified.

Decomposition:
- Shared package radar_pkg holds:
  - VID_W and AZ_W=12 constants.
  - The state enum {IDLE, BLANK, CAPTURE}.
  - The FIFO entry struct {data, bin, az, last}.
- One sub-module, sweep_fifo: synchronous first-word fall-through FIFO with parameterised depth and width, exposing full/empty.
- Edge detection and the FSM stay in the top module.

Test Plan:
- Reset with NUM_BINS=8; give 5 acp pulses, then a trig pulse 50 clk wide, then 8 sample_en strobes with video=0x100+i and out_ready=1 -> 8 entries out, bins 0..7, data 0x100..0x107, out_az=5, out_last only on bin 7, overflow=0.
- arp and acp rising in the same cycle with az_cnt=17 -> az_cnt=0; the next acp gives 1. 4096 acp pulses with no arp -> az_cnt wraps back to its start value.
- FIFO_DEPTH=4, NUM_BINS=8, out_ready=0 -> 4 entries held, bins 0..3. overflow=1 after the 5th strobe. Releasing out_ready then drains bins 0..3 only.
- New trig rise after bin 3 of a NUM_BINS=8 sweep -> trunc=1. The next sweep restarts at bin 0 with the newly latched azimuth, and no out_last appears for bins 0..3.
- sample_en strobes while trig is high (BLANK) -> no FIFO writes. rst driven low mid-CAPTURE -> out_valid=0, state IDLE, flags 0 immediately, without waiting for a clk edge.
- Build with CLUTTER_GATE_EN, gate_thr=0x080, video sequence 0x07F, 0x080, 0x200 -> out_data 0x000, 0x080, 0x200 with bins 0, 1, 2.
